// File: rtl/fir_sample_source.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_source
// Description : Buffered Q1.7 sample player with rate divider and zero flush,
//               driving the FIR datapath input over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_source #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int FLUSH_LEN = 8,
  parameter int DIV_W     = 8
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   seq_len,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] xn,
  output logic              xn_valid,
  input  logic              xn_ready,
  output logic [ADDR_W:0]   sample_idx,
  output logic              busy,
  output logic              done
);

  // One spare bit so sequence-plus-flush counts never wrap
  localparam int CNT_W = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_len;
  logic [DIV_W-1:0]  r_rate;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [CNT_W-1:0]  r_load_cnt;
  logic [CNT_W-1:0]  w_total;
  logic              w_start;
  logic              w_active;
  logic              w_xfer;
  logic              w_slot;
  logic              w_more;
  logic              w_tick;
  logic              w_load;

  assign w_start  = start && (seq_len != '0);
  assign w_active = (r_state == S_PLAY) || (r_state == S_FLUSH);
  assign w_total  = CNT_W'(r_len) + CNT_W'(FLUSH_LEN);
  assign w_xfer   = xn_valid && xn_ready;
  assign w_slot   = !xn_valid || xn_ready;
  assign w_more   = r_load_cnt < w_total;
  assign w_tick   = r_div_cnt == r_rate;
  assign w_load   = w_active && w_slot && w_tick && w_more;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (global_reset) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  // r_load_cnt is one past the index currently presented on xn
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_PLAY;
      S_PLAY:  if (w_xfer && (r_load_cnt == CNT_W'(r_len)))
                 w_next = (FLUSH_LEN == 0) ? S_DONE : S_FLUSH;
      S_FLUSH: if (w_xfer && !w_more) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Buffer contents survive reset so a sequence can be replayed
  always_ff @(posedge clk) begin
    if (wr_en && (r_state == S_IDLE)) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (global_reset || abort) begin
      xn         <= '0;
      xn_valid   <= 1'b0;
      sample_idx <= '0;
      r_div_cnt  <= '0;
      r_load_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_start) begin
        r_len      <= (seq_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : seq_len;
        r_rate     <= rate_div;
        r_div_cnt  <= '0;
        r_load_cnt <= '0;
      end
      if (w_active && w_slot) begin
        if (w_load) begin
          xn         <= (r_load_cnt < CNT_W'(r_len)) ? r_mem[r_load_cnt[ADDR_W-1:0]] : '0;
          xn_valid   <= 1'b1;
          sample_idx <= r_load_cnt[ADDR_W:0];
          r_div_cnt  <= '0;
          r_load_cnt <= r_load_cnt + 1'b1;
        end else begin
          xn_valid <= 1'b0;
          if (!w_tick) r_div_cnt <= r_div_cnt + 1'b1;
          if (!w_more) xn <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire
